// File: rtl/fp_operand_rx.sv
// fp_operand_rx: receives two FP operands from asynchronous pads as a
// nibble-serial, strobe-qualified frame and presents them to the adder
// core with a valid/ready handshake.
module fp_operand_rx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic [3:0]       pin_data,
   input  logic             pin_strobe,
   input  logic             pin_start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             busy,
   output logic             frame_err
);

   localparam int NIB     = 2 * WIDTH / 4;
   localparam int CW      = $clog2(NIB);
   localparam int ARM_MAX = SYNC_STAGES + 1;
   localparam int AW      = $clog2(ARM_MAX + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [2*WIDTH-1:0]   shreg, shreg_n;
   logic [WIDTH-1:0]     op_a_n, op_b_n;
   logic                 valid_n, err_n;

   logic [3:0]             data_sync [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] strobe_sync;
   logic [SYNC_STAGES-1:0] start_sync;
   logic                   strobe_s, start_s;
   logic                   strobe_d, start_d;
   logic                   strobe_rise_q, start_rise_q;
   logic [3:0]             data_q;
   logic [AW-1:0]          arm_cnt;
   logic                   armed;

   assign strobe_s = strobe_sync[SYNC_STAGES-1];
   assign start_s  = start_sync[SYNC_STAGES-1];
   assign armed    = (arm_cnt == AW'(ARM_MAX));
   assign busy     = (state != IDLE);

   // Pad synchronisers: every asynchronous pad passes through SYNC_STAGES flops.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         strobe_sync <= '0;
         start_sync  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 4'h0;
      end else begin
         strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], pin_strobe};
         start_sync  <= {start_sync[SYNC_STAGES-2:0], pin_start};
         data_sync[0] <= pin_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   // Arm counter keeps pads that were high through reset from looking like edges.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)    arm_cnt <= '0;
      else if (!armed) arm_cnt <= arm_cnt + AW'(1);
   end

   // Edge detection; rise pulses and the matching nibble are registered together.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         strobe_d      <= 1'b0;
         start_d       <= 1'b0;
         strobe_rise_q <= 1'b0;
         start_rise_q  <= 1'b0;
         data_q        <= 4'h0;
      end else begin
         strobe_d      <= strobe_s;
         start_d       <= start_s;
         strobe_rise_q <= strobe_s & ~strobe_d & armed;
         start_rise_q  <= start_s & ~start_d & armed;
         data_q        <= data_sync[SYNC_STAGES-1];
      end
   end

   // State and datapath registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         shreg     <= shreg_n;
         op_a      <= op_a_n;
         op_b      <= op_b_n;
         op_valid  <= valid_n;
         frame_err <= err_n;
      end
   end

   // Frame FSM: a start rise always wins over a strobe in RECV; HOLD drops new frames.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      op_a_n  = op_a;
      op_b_n  = op_b;
      valid_n = op_valid;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start_rise_q) begin
               state_n = RECV;
               cnt_n   = '0;
            end
         end
         RECV: begin
            if (start_rise_q) begin
               cnt_n = '0;
               err_n = 1'b1;
            end else if (strobe_rise_q) begin
               shreg_n = {shreg[2*WIDTH-5:0], data_q};
               if (cnt == CW'(NIB - 1)) begin
                  op_a_n  = shreg_n[2*WIDTH-1 -: WIDTH];
                  op_b_n  = shreg_n[WIDTH-1:0];
                  valid_n = 1'b1;
                  state_n = HOLD;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         HOLD: begin
            if (start_rise_q) err_n = 1'b1;
            if (op_valid && op_ready) begin
               valid_n = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fp_operand_rx.sv
// tb_fp_operand_rx: directed plus randomized frames for fp_operand_rx,
// checked against an arithmetic model of the frame format.
module tb_fp_operand_rx;

   localparam int WIDTH = 16;
   localparam int NIB   = 2 * WIDTH / 4;

   logic             wb_clk_i = 1'b0;
   logic             wb_rst_i;
   logic [3:0]       pin_data;
   logic             pin_strobe;
   logic             pin_start;
   logic [WIDTH-1:0] op_a, op_b;
   logic             op_valid;
   logic             op_ready;
   logic             busy;
   logic             frame_err;

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int err_long = 0;
   logic err_prev = 1'b0;

   logic [3:0] nibs [NIB];
   logic [31:0] exp_a, exp_b;
   int snap;

   fp_operand_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .pin_data  (pin_data),
      .pin_strobe(pin_strobe),
      .pin_start (pin_start),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .busy      (busy),
      .frame_err (frame_err)
   );

   // Free-running system clock.
   always #5 wb_clk_i = ~wb_clk_i;

   // Count frame_err pulses and any that last longer than one cycle.
   always @(negedge wb_clk_i) begin
      if (frame_err === 1'b1) err_seen++;
      if (frame_err === 1'b1 && err_prev === 1'b1) err_long++;
      err_prev = frame_err;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] d, input logic stb, input logic st);
      pin_data   = d;
      pin_strobe = stb;
      pin_start  = st;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic pulseStart();
      applyStimulus(pin_data, 1'b0, 1'b1);
      tick(4);
      applyStimulus(pin_data, 1'b0, 1'b0);
      tick(4);
   endtask

   task automatic sendNibble(input logic [3:0] n);
      applyStimulus(n, 1'b0, 1'b0);
      tick(4);
      applyStimulus(n, 1'b1, 1'b0);
      tick(4);
      applyStimulus(n, 1'b0, 1'b0);
      tick(3);
   endtask

   task automatic loadNibs(input logic [31:0] v);
      for (int i = 0; i < NIB; i++) nibs[i] = v[31-4*i -: 4];
   endtask

   task automatic sendFrame();
      pulseStart();
      for (int i = 0; i < NIB; i++) sendNibble(nibs[i]);
   endtask

   // Reference model: the frame is one big base-16 number, first nibble most significant.
   task automatic modelFrame();
      longint v = 0;
      longint half = longint'(1) << WIDTH;
      for (int i = 0; i < NIB; i++) v = v * 16 + longint'(nibs[i]);
      exp_a = 32'(v / half);
      exp_b = 32'(v % half);
   endtask

   task automatic handshake(input string tag);
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
      checkOutput({tag, "_valid_after_hs"}, 32'(op_valid), 32'd0);
      checkOutput({tag, "_busy_after_hs"}, 32'(busy), 32'd0);
   endtask

   // Directed scenarios followed by randomized frames, all in one linear sequence.
   initial begin
      op_ready = 1'b0;
      wb_rst_i = 1'b1;
      applyStimulus(4'h0, 1'b1, 1'b1);
      tick(3);
      checkOutput("rst_op_a", 32'(op_a), 32'd0);
      checkOutput("rst_op_b", 32'(op_b), 32'd0);
      checkOutput("rst_valid", 32'(op_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(frame_err), 32'd0);

      // Pads held high across reset release must not open a frame.
      snap = err_seen;
      wb_rst_i = 1'b0;
      tick(10);
      checkOutput("armhi_busy", 32'(busy), 32'd0);
      checkOutput("armhi_err", 32'(err_seen - snap), 32'd0);
      applyStimulus(4'h0, 1'b0, 1'b0);
      tick(4);
      checkOutput("armhi_busy_low", 32'(busy), 32'd0);

      // Frame 3C00/4000 with exact latency check on the final strobe.
      loadNibs(32'h3C00_4000);
      pulseStart();
      checkOutput("f1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < NIB - 1; i++) sendNibble(nibs[i]);
      applyStimulus(nibs[NIB-1], 1'b0, 1'b0);
      tick(4);
      applyStimulus(nibs[NIB-1], 1'b1, 1'b0);
      tick(3);
      checkOutput("f1_valid_edge2", 32'(op_valid), 32'd0);
      tick(1);
      checkOutput("f1_valid_edge3", 32'(op_valid), 32'd1);
      tick(2);
      applyStimulus(nibs[NIB-1], 1'b0, 1'b0);
      tick(3);
      checkOutput("f1_op_a", 32'(op_a), 32'h3C00);
      checkOutput("f1_op_b", 32'(op_b), 32'h4000);
      handshake("f1");

      // Back-pressure: hold op_ready low for 20 cycles.
      loadNibs(32'hABCD_1357);
      sendFrame();
      tick(20);
      checkOutput("bp_valid", 32'(op_valid), 32'd1);
      checkOutput("bp_op_a", 32'(op_a), 32'hABCD);
      checkOutput("bp_op_b", 32'(op_b), 32'h1357);
      handshake("bp");
      checkOutput("bp_hold_a", 32'(op_a), 32'hABCD);
      loadNibs(32'hC500_3800);
      sendFrame();
      checkOutput("f2_op_a", 32'(op_a), 32'hC500);
      checkOutput("f2_op_b", 32'(op_b), 32'h3800);
      handshake("f2");

      // Restart after three nibbles.
      snap = err_seen;
      pulseStart();
      for (int i = 0; i < 3; i++) sendNibble(4'hF);
      loadNibs(32'h1234_5678);
      sendFrame();
      checkOutput("rs_err", 32'(err_seen - snap), 32'd1);
      checkOutput("rs_op_a", 32'(op_a), 32'h1234);
      checkOutput("rs_op_b", 32'(op_b), 32'h5678);

      // New frame arriving during HOLD is dropped.
      snap = err_seen;
      loadNibs(32'h9999_AAAA);
      sendFrame();
      checkOutput("hold_err", 32'(err_seen - snap), 32'd1);
      checkOutput("hold_op_a", 32'(op_a), 32'h1234);
      checkOutput("hold_op_b", 32'(op_b), 32'h5678);
      checkOutput("hold_valid", 32'(op_valid), 32'd1);
      handshake("hold");

      // Reset in the middle of a frame.
      pulseStart();
      for (int i = 0; i < 5; i++) sendNibble(4'h7);
      wb_rst_i = 1'b1;
      tick(2);
      checkOutput("mrst_op_a", 32'(op_a), 32'd0);
      checkOutput("mrst_op_b", 32'(op_b), 32'd0);
      checkOutput("mrst_busy", 32'(busy), 32'd0);
      checkOutput("mrst_valid", 32'(op_valid), 32'd0);
      wb_rst_i = 1'b0;
      tick(5);
      loadNibs(32'h4200_BEEF);
      sendFrame();
      checkOutput("mrst_f_a", 32'(op_a), 32'h4200);
      checkOutput("mrst_f_b", 32'(op_b), 32'hBEEF);
      handshake("mrst");

      // Randomized frames: plain, aborted-prefix, and HOLD intrusion.
      for (int f = 0; f < 8; f++) begin
         int mode;
         logic [31:0] prev_a, prev_b;
         mode = int'($urandom_range(0, 2));
         for (int i = 0; i < NIB; i++) nibs[i] = 4'($urandom_range(0, 15));
         modelFrame();
         snap = err_seen;
         if (mode == 0) sendNibble(4'($urandom_range(0, 15)));
         if (mode == 1) begin
            pulseStart();
            for (int k = 0; k < int'($urandom_range(1, NIB - 1)); k++)
               sendNibble(4'($urandom_range(0, 15)));
         end
         sendFrame();
         checkOutput("rnd_op_a", 32'(op_a), exp_a);
         checkOutput("rnd_op_b", 32'(op_b), exp_b);
         checkOutput("rnd_err", 32'(err_seen - snap), (mode == 1) ? 32'd1 : 32'd0);
         if (mode == 2) begin
            prev_a = exp_a;
            prev_b = exp_b;
            snap = err_seen;
            for (int i = 0; i < NIB; i++) nibs[i] = 4'($urandom_range(0, 15));
            sendFrame();
            checkOutput("rnd_intr_err", 32'(err_seen - snap), 32'd1);
            checkOutput("rnd_intr_a", 32'(op_a), prev_a);
            checkOutput("rnd_intr_b", 32'(op_b), prev_b);
         end
         tick(int'($urandom_range(0, 15)));
         checkOutput("rnd_valid", 32'(op_valid), 32'd1);
         handshake("rnd");
      end

      checkOutput("err_pulse_width", 32'(err_long), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
